// File: rtl/mov_avg_scheduler.sv
// Round-robin front end that shares one moving-average engine between NUM_CH
// sample sources, with a watchdog that abandons a transaction if the engine hangs.
module mov_avg_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable_i,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic                     eng_valid_o,
  output logic [DATA_W-1:0]        eng_data_o,
  output logic [$clog2(NUM_CH)-1:0] eng_ch_o,
  input  logic                     eng_done_i,
  input  logic [DATA_W-1:0]        eng_avg_i,
  output logic                     res_valid_o,
  output logic [$clog2(NUM_CH)-1:0] res_ch_o,
  output logic [DATA_W-1:0]        res_avg_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [CH_W-1:0]     eng_ch_q, eng_ch_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [DATA_W-1:0]   eng_data_q, eng_data_d;
  logic [DATA_W-1:0]   res_avg_q, res_avg_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                eng_valid_q, eng_valid_d;
  logic                res_valid_q, res_valid_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                grant_found;
  logic [CH_W-1:0]     grant_idx;
  logic [CH_W-1:0]     cand;

  // Search upward from the channel after the last winner; CH_W-bit wrap gives the modulo.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = ptr_q + CH_W'(i);
      if (!grant_found && req_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    eng_ch_d    = eng_ch_q;
    eng_data_d  = eng_data_q;
    res_ch_d    = res_ch_q;
    res_avg_d   = res_avg_q;
    timeout_d   = timeout_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    eng_valid_d = 1'b0;
    res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i && grant_found) begin
          eng_data_d  = req_data_i[grant_idx*DATA_W +: DATA_W];
          eng_ch_d    = grant_idx;
          ptr_d       = grant_idx;
          ack_d       = {{(NUM_CH-1){1'b0}}, 1'b1} << grant_idx;
          eng_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Done takes priority over the watchdog expiring in the same cycle.
        if (eng_done_i) begin
          res_avg_d   = eng_avg_i;
          res_ch_d    = eng_ch_q;
          res_valid_d = 1'b1;
          state_d     = DELIVER;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DELIVER: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= CH_W'(NUM_CH - 1);
      eng_ch_q    <= '0;
      eng_data_q  <= '0;
      res_ch_q    <= '0;
      res_avg_q   <= '0;
      ack_q       <= '0;
      eng_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      eng_ch_q    <= eng_ch_d;
      eng_data_q  <= eng_data_d;
      res_ch_q    <= res_ch_d;
      res_avg_q   <= res_avg_d;
      ack_q       <= ack_d;
      eng_valid_q <= eng_valid_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ack_o       = ack_q;
  assign eng_valid_o = eng_valid_q;
  assign eng_data_o  = eng_data_q;
  assign eng_ch_o    = eng_ch_q;
  assign res_valid_o = res_valid_q;
  assign res_ch_o    = res_ch_q;
  assign res_avg_o   = res_avg_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mov_avg_scheduler.sv
// Self-checking bench for mov_avg_scheduler: directed vector table, hand-written
// corner sequences, and randomized traffic against a round-robin reference model.
module tb_mov_avg_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable_i;
  logic [3:0]  req_i;
  logic [31:0] req_data_i;
  logic [3:0]  ack_o;
  logic        eng_valid_o;
  logic [7:0]  eng_data_o;
  logic [1:0]  eng_ch_o;
  logic        eng_done_i;
  logic [7:0]  eng_avg_i;
  logic        res_valid_o;
  logic [1:0]  res_ch_o;
  logic [7:0]  res_avg_o;
  logic        busy_o;
  logic        timeout_o;

  mov_avg_scheduler #(.NUM_CH(4), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .req_i(req_i),
    .req_data_i(req_data_i), .ack_o(ack_o), .eng_valid_o(eng_valid_o),
    .eng_data_o(eng_data_o), .eng_ch_o(eng_ch_o), .eng_done_i(eng_done_i),
    .eng_avg_i(eng_avg_i), .res_valid_o(res_valid_o), .res_ch_o(res_ch_o),
    .res_avg_o(res_avg_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int lastGrant = 3;
  logic expTimeout = 1'b0;
  logic [31:0] curData;

  typedef struct {
    logic [3:0] req;
    int         lat;
    logic [7:0] avg;
    int         expCh;
  } vec_t;

  vec_t vecs[8];
  int   fairOrder[5];

  // Every comparison funnels through here so the summary counts stay honest.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arbiter: first requesting channel after the previous winner, modulo 4.
  function automatic int rrPick(input logic [3:0] mask);
    for (int i = 1; i <= 4; i++) begin
      if (mask[(lastGrant + i) % 4]) return (lastGrant + i) % 4;
    end
    return -1;
  endfunction

  // Runs one full transaction from the current IDLE-side negedge: waits for the
  // strobe, plays the engine with latency lat (>16 means never done), checks result.
  task automatic applyStimulus(input int expCh, input int lat, input logic [7:0] avg,
                               input logic [3:0] nextReq, input logic [31:0] nextData,
                               input logic nextEnable);
    int waited = 0;
    logic [7:0] expData;
    expData = curData[expCh*8 +: 8];
    while (!eng_valid_o && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("strobeSeen", {31'd0, eng_valid_o}, 32'd1);
    if (!eng_valid_o) return;
    checkOutput("ackOneHot", {28'd0, ack_o}, 32'd1 << expCh);
    checkOutput("engCh", {30'd0, eng_ch_o}, expCh);
    checkOutput("engData", {24'd0, eng_data_o}, {24'd0, expData});
    checkOutput("busyIssue", {31'd0, busy_o}, 32'd1);
    req_i      = nextReq;
    req_data_i = nextData;
    curData    = nextData;
    enable_i   = nextEnable;
    lastGrant  = expCh;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("ackOneCycle", {28'd0, ack_o}, 32'd0);
        checkOutput("strobeOneCycle", {31'd0, eng_valid_o}, 32'd0);
        checkOutput("engDataHeld", {24'd0, eng_data_o}, {24'd0, expData});
      end
      checkOutput("noEarlyResult", {31'd0, res_valid_o}, 32'd0);
      eng_done_i = (c == lat);
      eng_avg_i  = (c == lat) ? avg : 8'($urandom);
      if (c == lat) break;
    end
    @(negedge clk);
    eng_done_i = 1'b0;
    if (lat <= 16) begin
      checkOutput("resValid", {31'd0, res_valid_o}, 32'd1);
      checkOutput("resCh", {30'd0, res_ch_o}, expCh);
      checkOutput("resAvg", {24'd0, res_avg_o}, {24'd0, avg});
      checkOutput("busyDeliver", {31'd0, busy_o}, 32'd1);
      @(negedge clk);
      checkOutput("resOneCycle", {31'd0, res_valid_o}, 32'd0);
      checkOutput("resAvgHeld", {24'd0, res_avg_o}, {24'd0, avg});
    end else begin
      expTimeout = 1'b1;
      checkOutput("noResOnTimeout", {31'd0, res_valid_o}, 32'd0);
    end
    checkOutput("busyIdle", {31'd0, busy_o}, 32'd0);
    checkOutput("timeoutFlag", {31'd0, timeout_o}, {31'd0, expTimeout});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL globalTimeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] hung");
  end

  initial begin
    logic [3:0]  nr;
    logic [31:0] nd;
    int          e;
    int          e2;

    vecs[0] = '{4'b0001, 3,  8'h10, 0};
    vecs[1] = '{4'b1111, 1,  8'h21, 1};
    vecs[2] = '{4'b1001, 2,  8'h33, 3};
    vecs[3] = '{4'b1001, 5,  8'h44, 0};
    vecs[4] = '{4'b0110, 4,  8'h55, 1};
    vecs[5] = '{4'b0100, 7,  8'h66, 2};
    vecs[6] = '{4'b1011, 2,  8'h77, 3};
    vecs[7] = '{4'b0010, 3,  8'h88, 1};
    fairOrder = '{2, 3, 0, 1, 2};

    rst_n = 1'b0; enable_i = 1'b1; req_i = 4'b0; eng_done_i = 1'b0; eng_avg_i = 8'h0;
    curData = 32'h43424140;
    req_data_i = curData;
    repeat (3) @(negedge clk);
    checkOutput("resetOutputs", {4'd0, ack_o, eng_valid_o, eng_data_o, eng_ch_o,
                res_valid_o, res_ch_o, res_avg_o, busy_o, timeout_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      req_i = vecs[i].req;
      applyStimulus(vecs[i].expCh, vecs[i].lat, vecs[i].avg, 4'b0, curData, 1'b1);
    end

    // All channels requesting continuously: strict rotation.
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(fairOrder[i], 2, 8'hA0 + 8'(i), 4'b1111, curData, 1'b1);
    end

    // Done lands on the very cycle the watchdog would expire.
    req_i = 4'b0001;
    applyStimulus(0, 16, 8'h99, 4'b0, curData, 1'b1);

    // Stray done while idle must not produce a result.
    eng_done_i = 1'b1; eng_avg_i = 8'hEE;
    @(negedge clk);
    eng_done_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idleDoneNoRes", {31'd0, res_valid_o}, 32'd0);
      checkOutput("idleDoneBusy", {31'd0, busy_o}, 32'd0);
      checkOutput("idleDoneAvgHeld", {24'd0, res_avg_o}, 32'h99);
    end

    // Hung engine, then the next request is still served.
    req_i = 4'b0010;
    applyStimulus(1, 99, 8'h00, 4'b0, curData, 1'b1);
    req_i = 4'b1000;
    applyStimulus(3, 2, 8'h5A, 4'b0, curData, 1'b1);

    // Randomized traffic against the round-robin model.
    req_i = 4'b0101;
    for (int t = 0; t < 30; t++) begin
      e  = rrPick(req_i);
      nr = (req_i & ~(4'b1 << e)) | 4'($urandom_range(0, 15));
      if (nr == 4'b0) nr = 4'b1 << $urandom_range(0, 3);
      nd = curData;
      for (int k = 0; k < 4; k++) begin
        if (nr[k] && !(req_i[k] && k != e)) nd[k*8 +: 8] = 8'($urandom);
      end
      applyStimulus(e, $urandom_range(1, 20), 8'($urandom), nr, nd, 1'b1);
    end

    // Enable dropped mid-transaction: result still delivered, no new grant.
    req_i = 4'b0011;
    e  = rrPick(4'b0011);
    e2 = (e == 0) ? 1 : 0;
    applyStimulus(e, 3, 8'h3C, 4'b0011 & ~(4'b1 << e), curData, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("disabledNoAck", {28'd0, ack_o}, 32'd0);
      checkOutput("disabledIdle", {31'd0, busy_o}, 32'd0);
    end
    enable_i = 1'b1;
    applyStimulus(e2, 2, 8'hC3, 4'b0, curData, 1'b1);

    // Reset in WAIT abandons the transaction.
    req_i = 4'b0100;
    for (int i = 0; i < 8 && !eng_valid_o; i++) @(negedge clk);
    checkOutput("rstStrobeSeen", {31'd0, eng_valid_o}, 32'd1);
    req_i = 4'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncResetOutputs", {4'd0, ack_o, eng_valid_o, eng_data_o, eng_ch_o,
                res_valid_o, res_ch_o, res_avg_o, busy_o, timeout_o}, 32'd0);
    eng_done_i = 1'b1; eng_avg_i = 8'h77;
    @(negedge clk);
    eng_done_i = 1'b0;
    rst_n = 1'b1;
    lastGrant = 3;
    expTimeout = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("postResetNoRes", {31'd0, res_valid_o}, 32'd0);
      checkOutput("postResetNoAck", {28'd0, ack_o}, 32'd0);
      checkOutput("postResetIdle", {31'd0, busy_o}, 32'd0);
    end
    req_i = 4'b0110;
    applyStimulus(rrPick(4'b0110), 4, 8'h1F, 4'b0, curData, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
